rr_mux_stage: RTL and testbench
===============================

Name: rr_mux_stage

Overview:
- Parametrised N-input, WIDTH-bit selector stage with a registered output and valid/ready handshake.
- Two select modes, chosen by a runtime pin:
  - Fixed mode: an externally supplied binary select picks the input.
  - Round-robin mode: a rotating-priority arbiter picks among the valid inputs.
- Used in the pipeline wherever several producers share one downstream consumer, such as writeback or forwarding merge points. It supersedes chains of single-bit 2:1 muxes.

Parameters:
- WIDTH, 64, data width per channel in bits.
- N, 4, number of input channels (N >= 2; need not be a power of two).
- SELW, $clog2(N), width of the select and channel-ID fields.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  channel i has data.
- in_ready  output  N  channel i transfers this cycle; combinational.
- sel  input  SELW  channel select in fixed mode.
- rr_en  input  1  1 = round-robin mode, 0 = fixed mode.
- flush  input  1  synchronous kill of the output register.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SELW  registered ID of the channel that produced out_data.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, out_data=0, out_sel=0, rr pointer ptr=N-1, so channel 0 has first priority.
- load = (!out_valid || out_ready) && !flush. This is the one-deep pipe rule: a new item can enter in the same cycle the old one leaves.
- Grant in fixed mode:
  - grant[i] = (i == sel) && in_valid[i].
  - sel >= N grants nothing.
- Grant in round-robin mode:
  - Scan channels ptr+1, ptr+2, ... mod N.
  - The first channel with in_valid set is granted; at most one grant.
- in_ready[i] = load && grant[i]. It is one-hot or zero, and never depends on out_data.
- A transfer occurs when some grant is set and load is true. On the next edge:
  - out_data <= in_data[granted].
  - out_sel <= granted.
  - out_valid <= 1.
  - ptr <= granted. ptr updates in both modes, so a switch to round-robin resumes fairly.
- load true, no grant: out_valid <= 0. out_data and out_sel hold their old values.
- load false, no flush (stall, out_valid=1 and out_ready=0): out_data, out_sel and out_valid hold; all in_ready are 0.
- flush=1:
  - out_valid <= 0 next edge.
  - in_ready all 0 in that cycle; no transfer.
  - ptr unchanged.
  - flush takes priority over out_ready and over in_valid.
- Latency: an accepted input appears at the output exactly 1 cycle later. Throughput is 1 item per cycle while out_ready=1.
- Mode or sel changes take effect in the cycle they are presented. An item already in the output register is not affected.
- Reset asserted mid-transfer: the item is lost, outputs go immediately to their reset values, and no in_ready is asserted while reset=0.
- Widths: no arithmetic on data. The ptr+k wrap is computed modulo N, not modulo 2^SELW.

Test Plan:
- Reset, then fixed mode with sel=2, in_valid=4'b0100, in_data ch2=64'hDEAD_BEEF, out_ready=1.
  - Same cycle: in_ready=4'b0100.
  - Next cycle: out_valid=1, out_data=64'hDEAD_BEEF, out_sel=2.
- Round-robin fairness: rr_en=1, all four in_valid held at 1 with distinct data, out_ready=1 for 8 cycles.
  - out_sel sequence is 0,1,2,3,0,1,2,3.
  - Exactly one in_ready is high per cycle.
- Backpressure:
  - Setup: out_valid=1, out_sel=1; drop out_ready for 3 cycles while inputs stay valid.
  - During the stall: out_data and out_sel are stable and in_ready=0.
  - On the cycle out_ready returns: a new transfer occurs, and the next out_sel is 2.
- Flush while stalled with valid inputs pending:
  - Next cycle out_valid=0, no in_ready pulse, and ptr is unchanged.
  - The following grant comes from ptr+1.
- Non-power-of-two: N=3, rr_en=1, in_valid=3'b101, starting from ptr=2.
  - Grant order is 0,2,0,2, and channel 3 never appears.
  - In fixed mode, sel=3 gives no grant and out_valid drops to 0.
- Async reset mid-stream: pull reset low between clock edges.
  - Outputs go to 0 without waiting for a clock edge.
  - After release with all inputs valid, the first grant is channel 0.

Source files
------------

// File: rtl/rr_mux_stage_if.sv
// rtl/rr_mux_stage_if.sv - handshake bundle between producers, the selector stage and its consumer
//
// Signals:
//   in_data   N*WIDTH  channel i data in bits [i*WIDTH +: WIDTH]
//   in_valid  N        channel i has data
//   in_ready  N        channel i transfers this cycle (one-hot or zero)
//   sel       SELW     channel select used in fixed mode
//   rr_en     1        1 = round-robin, 0 = fixed select
//   flush     1        synchronous kill of the output register
//   out_data  WIDTH    registered selected data
//   out_sel   SELW     registered ID of the channel that produced out_data
//   out_valid 1        out_data is valid
//   out_ready 1        consumer accepts out_data
// Modports: slave = the selector stage, master = the surrounding environment.
interface rr_mux_stage_if #(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    sel;
    logic               rr_en;
    logic               flush;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data, in_valid, sel, rr_en, flush, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    modport master (
        output in_data, in_valid, sel, rr_en, flush, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/rr_mux_stage.sv
// rtl/rr_mux_stage.sv - N-input selector stage, fixed or round-robin select, registered output
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (0 = in reset)
//   bus    rr_mux_stage_if.slave: per-channel valid/ready/data in, one registered
//          valid/ready/data/sel out, plus sel, rr_en and flush controls
module rr_mux_stage #(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    rr_mux_stage_if.slave bus
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  gidx;
    logic             gany;
    logic [SELW:0]    scan;
    logic             load;
    logic [WIDTH-1:0] data_q;
    logic [SELW-1:0]  sel_q;
    logic             valid_q;

    // Grant selection. Round-robin walks ptr+1 .. ptr+N; the index is wrapped
    // modulo N (not 2^SELW) so non-power-of-two N never reaches a phantom channel.
    always_comb begin
        gany = 1'b0;
        gidx = '0;
        scan = '0;
        if (bus.rr_en) begin
            for (int k = 1; k <= N; k++) begin
                scan = {1'b0, ptr} + (SELW+1)'(k);
                if (scan >= (SELW+1)'(N)) begin
                    scan = scan - (SELW+1)'(N);
                end
                if (!gany && bus.in_valid[scan[SELW-1:0]]) begin
                    gany = 1'b1;
                    gidx = scan[SELW-1:0];
                end
            end
        end else begin
            // A select value >= N matches no channel and so grants nothing.
            for (int i = 0; i < N; i++) begin
                if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
                    gany = 1'b1;
                    gidx = SELW'(i);
                end
            end
        end
    end

    // One-deep pipe: accept when the register is empty or draining this cycle.
    // Gated by reset so no producer sees a transfer while the stage is held in reset.
    assign load = (!valid_q || bus.out_ready) && !bus.flush && reset;

    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < N; i++) begin
            bus.in_ready[i] = load && gany && (gidx == SELW'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr     <= SELW'(N-1);
        end else if (load) begin
            if (gany) begin
                data_q  <= bus.in_data[int'(gidx)*WIDTH +: WIDTH];
                sel_q   <= gidx;
                valid_q <= 1'b1;
                // Tracked in fixed mode too, so switching to round-robin stays fair.
                ptr     <= gidx;
            end else begin
                valid_q <= 1'b0;
            end
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_rr_mux_stage.sv
// tb/tb_rr_mux_stage.sv - scoreboard bench for rr_mux_stage with N=4 and N=3 instances
module tb_rr_mux_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    rr_mux_stage_if #(.WIDTH(64), .N(4)) a ();
    rr_mux_stage_if #(.WIDTH(64), .N(3)) b ();

    rr_mux_stage #(.WIDTH(64), .N(4)) u4 (.clk(clk), .reset(reset), .bus(a));
    rr_mux_stage #(.WIDTH(64), .N(3)) u3 (.clk(clk), .reset(reset), .bus(b));

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  sel;
    } item_t;

    item_t qa[$];
    item_t qb[$];
    item_t ita;
    item_t itb;
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic item_t mk(input logic [63:0] d, input int s);
        item_t it;
        it.data = d;
        it.sel  = 2'(s);
        return it;
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Monitors: an item leaves the register when out_valid && out_ready at the
    // next edge; a flush with out_ready low discards it unseen.
    always @(negedge clk) begin
        if (reset && a.out_valid && (a.out_ready || a.flush)) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_output actual_sel=%0d actual_data=%0h", a.out_sel, a.out_data);
            end else begin
                ita = qa.pop_front();
                if (a.out_ready) begin
                    chk("a_out_data", a.out_data, ita.data);
                    chk("a_out_sel", 64'(a.out_sel), 64'(ita.sel));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset && b.out_valid && (b.out_ready || b.flush)) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_output actual_sel=%0d actual_data=%0h", b.out_sel, b.out_data);
            end else begin
                itb = qb.pop_front();
                if (b.out_ready) begin
                    chk("b_out_data", b.out_data, itb.data);
                    chk("b_out_sel", 64'(b.out_sel), 64'(itb.sel));
                end
            end
        end
    end

    initial begin
        int g3[4];
        g3 = '{0, 2, 0, 2};

        reset = 1'b0;
        a.in_data = '0; a.in_valid = '0; a.sel = '0; a.rr_en = 1'b0; a.flush = 1'b0; a.out_ready = 1'b0;
        b.in_data = '0; b.in_valid = '0; b.sel = '0; b.rr_en = 1'b0; b.flush = 1'b0; b.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 64'(a.out_valid), 64'd0);
        chk("rst_out_data", a.out_data, 64'd0);
        chk("rst_out_sel", 64'(a.out_sel), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Fixed mode, sel=2
        a.rr_en = 1'b0;
        a.sel = 2'd2;
        a.in_data[2*64 +: 64] = 64'hDEAD_BEEF;
        a.in_valid = 4'b0100;
        a.out_ready = 1'b1;
        #1 chk("fix_in_ready", 64'(a.in_ready), 64'b0100);
        qa.push_back(mk(64'hDEAD_BEEF, 2));
        cyc;
        a.in_valid = '0;
        #1 chk("fix_out_valid", 64'(a.out_valid), 64'd1);
        cyc;

        // Reset pulse between edges so round-robin starts at channel 0
        reset = 1'b0;
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) a.in_data[i*64 +: 64] = 64'h1000 + 64'(i);
        a.rr_en = 1'b1;
        a.in_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1 chk("rr_in_ready", 64'(a.in_ready), 64'b0001 << (k % 4));
            qa.push_back(mk(64'h1000 + 64'(k % 4), k % 4));
            cyc;
        end
        a.in_valid = '0;
        cyc;

        // Backpressure: get channel 1 into the register, then stall 3 cycles
        a.in_valid = 4'hF;
        #1 chk("bp_pre0_in_ready", 64'(a.in_ready), 64'b0001);
        qa.push_back(mk(64'h1000, 0));
        cyc;
        #1 chk("bp_pre1_in_ready", 64'(a.in_ready), 64'b0010);
        qa.push_back(mk(64'h1001, 1));
        cyc;
        a.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", 64'(a.in_ready), 64'd0);
            chk("bp_out_sel", 64'(a.out_sel), 64'd1);
            chk("bp_out_data", a.out_data, 64'h1001);
            cyc;
        end
        a.out_ready = 1'b1;
        #1 chk("bp_resume_in_ready", 64'(a.in_ready), 64'b0100);
        qa.push_back(mk(64'h1002, 2));
        cyc;

        // Flush while stalled with all inputs pending; ptr stays at 2
        a.out_ready = 1'b0;
        #1 chk("fl_stall_in_ready", 64'(a.in_ready), 64'd0);
        cyc;
        a.flush = 1'b1;
        #1 chk("fl_in_ready", 64'(a.in_ready), 64'd0);
        cyc;
        a.flush = 1'b0;
        chk("fl_out_valid", 64'(a.out_valid), 64'd0);
        a.out_ready = 1'b1;
        #1 chk("fl_next_in_ready", 64'(a.in_ready), 64'b1000);
        qa.push_back(mk(64'h1003, 3));
        cyc;
        a.in_valid = '0;
        cyc;

        // Async reset mid-stream
        a.in_valid = 4'hF;
        #1 chk("ar_pre0_in_ready", 64'(a.in_ready), 64'b0001);
        qa.push_back(mk(64'h1000, 0));
        cyc;
        #1 chk("ar_pre1_in_ready", 64'(a.in_ready), 64'b0010);
        qa.push_back(mk(64'h1001, 1));
        cyc;
        #2;
        reset = 1'b0;
        qa.delete();
        #1;
        chk("ar_out_valid", 64'(a.out_valid), 64'd0);
        chk("ar_out_data", a.out_data, 64'd0);
        chk("ar_out_sel", 64'(a.out_sel), 64'd0);
        chk("ar_in_ready_in_reset", 64'(a.in_ready), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("ar_first_grant", 64'(a.in_ready), 64'b0001);
        qa.push_back(mk(64'h1000, 0));
        cyc;
        a.in_valid = '0;
        cyc;

        // N=3: round-robin from ptr=2 with in_valid=101, then sel=3 in fixed mode
        for (int i = 0; i < 3; i++) b.in_data[i*64 +: 64] = 64'h3000 + 64'(i);
        b.rr_en = 1'b1;
        b.out_ready = 1'b1;
        b.in_valid = 3'b101;
        for (int k = 0; k < 4; k++) begin
            #1 chk("n3_in_ready", 64'(b.in_ready), 64'b001 << g3[k]);
            qb.push_back(mk(64'h3000 + 64'(g3[k]), g3[k]));
            cyc;
        end
        b.rr_en = 1'b0;
        b.sel = 2'd3;
        #1 chk("n3_sel3_in_ready", 64'(b.in_ready), 64'd0);
        cyc;
        #1 chk("n3_sel3_out_valid", 64'(b.out_valid), 64'd0);
        b.in_valid = '0;
        cyc;
        cyc;

        chk("qa_drained", 64'(qa.size()), 64'd0);
        chk("qb_drained", 64'(qb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
